// File: rtl/activation_pkg.sv
// Shared sizing defaults, activation-type encodings and tanh-PWL constants
// for the activation stage and its per-lane datapath.
package activation_pkg;

  localparam int DEF_MAT_MUL_SIZE = 32'sd8;
  localparam int DEF_DWIDTH       = 32'sd8;
  localparam int DEF_MASK_WIDTH   = 32'sd8;

  typedef enum logic {
    ACT_RELU = 1'b0,
    ACT_TANH = 1'b1
  } act_type_e;

  // Piecewise segments of the tanh approximation, chosen from |x| in stage 1
  typedef enum logic [1:0] {
    SEG_LOW = 2'd0,
    SEG_MID = 2'd1,
    SEG_SAT = 2'd2
  } seg_e;

  localparam int TANH_SEG_LO_LIMIT = 32'sd16;
  localparam int TANH_SEG_HI_LIMIT = 32'sd32;
  localparam int TANH_ONE          = 32'sd64;
  localparam int TANH_SLOPE        = 32'sd3;
  localparam int TANH_OFFSET       = 32'sd32;

endpackage

// File: rtl/activation_lane.sv
// One lane of the activation pipeline: stage 1 registers sign/|x|/segment,
// stage 2 registers the ReLU or tanh-PWL result with masking applied.
module activation_lane
  import activation_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_s1,
  input  logic              load_s2,
  input  logic [DWIDTH-1:0] x,
  input  logic              mask,
  input  act_type_e         act_type,
  output logic [DWIDTH-1:0] y
);

  localparam int AW = DWIDTH + 32'sd1;

  logic              sign_s;
  logic [AW-1:0]     abs_s;
  seg_e              seg_s;
  logic              sign_r;
  logic [AW-1:0]     abs_r;
  seg_e              seg_r;
  logic              mask_r;
  act_type_e         type_r;
  logic [DWIDTH-1:0] mag_s;
  logic [DWIDTH-1:0] res_s;

  // Stage-1 decode: magnitude is one bit wider so the most negative input stays exact
  always_comb begin
    sign_s = x[DWIDTH-1];
    if (sign_s) begin
      abs_s = {AW{1'b0}} - {x[DWIDTH-1], x};
    end else begin
      abs_s = {1'b0, x};
    end
    if (abs_s < AW'(TANH_SEG_LO_LIMIT)) begin
      seg_s = SEG_LOW;
    end else if (abs_s < AW'(TANH_SEG_HI_LIMIT)) begin
      seg_s = SEG_MID;
    end else begin
      seg_s = SEG_SAT;
    end
  end

  // Stage-2 function: the tanh magnitude never exceeds 64, so it fits in a lane
  always_comb begin
    case (seg_r)
      SEG_LOW: mag_s = abs_r[DWIDTH-1:0] * DWIDTH'(TANH_SLOPE);
      SEG_MID: mag_s = abs_r[DWIDTH-1:0] + DWIDTH'(TANH_OFFSET);
      SEG_SAT: mag_s = DWIDTH'(TANH_ONE);
      default: mag_s = DWIDTH'(TANH_ONE);
    endcase
    if (!mask_r) begin
      res_s = {DWIDTH{1'b0}};
    end else if (type_r == ACT_TANH) begin
      if (sign_r) begin
        res_s = {DWIDTH{1'b0}} - mag_s;
      end else begin
        res_s = mag_s;
      end
    end else if (sign_r | abs_r[AW-1]) begin
      res_s = {DWIDTH{1'b0}};
    end else begin
      res_s = abs_r[DWIDTH-1:0];
    end
  end

  // Pipeline registers; each stage only advances on a valid beat so bubbles hold data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_r <= 1'b0;
      abs_r  <= {AW{1'b0}};
      seg_r  <= SEG_LOW;
      mask_r <= 1'b0;
      type_r <= ACT_RELU;
      y      <= {DWIDTH{1'b0}};
    end else if (clear) begin
      sign_r <= 1'b0;
      abs_r  <= {AW{1'b0}};
      seg_r  <= SEG_LOW;
      mask_r <= 1'b0;
      type_r <= ACT_RELU;
      y      <= {DWIDTH{1'b0}};
    end else begin
      if (load_s1) begin
        sign_r <= sign_s;
        abs_r  <= abs_s;
        seg_r  <= seg_s;
        mask_r <= mask;
        type_r <= act_type;
      end else begin
        sign_r <= sign_r;
        abs_r  <= abs_r;
        seg_r  <= seg_r;
        mask_r <= mask_r;
        type_r <= type_r;
      end
      if (load_s2) begin
        y <= res_s;
      end else begin
        y <= y;
      end
    end
  end

endmodule

// File: rtl/activation.sv
// Elementwise activation stage between pooling and the output buffer writer:
// MAT_MUL_SIZE lanes, two-cycle latency, tile-done counter and full bypass.
module activation
  import activation_pkg::*;
#(
  parameter int MAT_MUL_SIZE = DEF_MAT_MUL_SIZE,
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int MASK_WIDTH   = DEF_MASK_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_activation,
  input  logic                           activation_type,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           out_data_available,
  output logic                           done_activation
);

  localparam int CW = $clog2(MAT_MUL_SIZE + 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(MAT_MUL_SIZE);

  logic                           clear_s;
  logic                           v1_r;
  logic                           v2_r;
  logic                           done_r;
  logic [CW-1:0]                  count_r;
  logic [CW-1:0]                  count_next_s;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] lane_out_s;

  // Disabling the block doubles as a synchronous clear of all internal state
  assign clear_s = ~enable_activation;

  for (genvar i = 0; i < MAT_MUL_SIZE; i++) begin : g_lane
    activation_lane #(
      .DWIDTH(DWIDTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear_s),
      .load_s1  (in_data_available),
      .load_s2  (v1_r),
      .x        (inp_data[i*DWIDTH +: DWIDTH]),
      .mask     (validity_mask[i]),
      .act_type (act_type_e'(activation_type)),
      .y        (lane_out_s[i*DWIDTH +: DWIDTH])
    );
  end

  // Saturating count of output beats
  always_comb begin
    if (v2_r && (count_r != CNT_FULL)) begin
      count_next_s = count_r + CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Valid pipeline, beat counter and sticky done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      count_r <= {CW{1'b0}};
      done_r  <= 1'b0;
    end else if (clear_s) begin
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      count_r <= {CW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      v1_r    <= in_data_available;
      v2_r    <= v1_r;
      count_r <= count_next_s;
      done_r  <= done_r | (count_next_s == CNT_FULL);
    end
  end

  // Output select: pipeline results when enabled, straight wires when bypassed
  always_comb begin
    if (enable_activation) begin
      out_data           = lane_out_s;
      out_data_available = v2_r;
      done_activation    = done_r;
    end else begin
      out_data           = inp_data;
      out_data_available = in_data_available;
      done_activation    = 1'b1;
    end
  end

endmodule

// File: tb/tb_activation.sv
// Self-checking bench for activation: vector table plus scoreboard-checked
// sequences for tile-done timing, bypass and asynchronous reset.
module tb_activation;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_activation;
  logic        activation_type;
  logic        in_data_available;
  logic [63:0] inp_data;
  logic [7:0]  validity_mask;
  logic [63:0] out_data;
  logic        out_data_available;
  logic        done_activation;

  typedef struct {
    logic        t;
    logic [7:0]  m;
    logic [63:0] d;
    logic [63:0] e;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } sb_t;

  sb_t  sb [$];
  vec_t vecs [6];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   seen = 0;
  logic exp_done = 1'b0;
  logic mon_en = 1'b0;
  logic [63:0] rd [8];
  logic        rt [8];
  logic [7:0]  rm [8];

  activation dut (
    .clk                (clk),
    .reset              (reset),
    .enable_activation  (enable_activation),
    .activation_type    (activation_type),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_activation    (done_activation)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    int a [8];
    logic [63:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = 64'd0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i][7:0];
    return r;
  endfunction

  // Reference model in plain integer arithmetic
  function automatic logic [63:0] model(input logic t, input logic [7:0] m, input logic [63:0] d);
    logic [63:0] r;
    logic signed [7:0] xs;
    int x, a, mm, y;
    r = 64'd0;
    for (int i = 0; i < 8; i++) begin
      xs = d[i*8 +: 8];
      x = xs;
      if (t == 1'b0) begin
        y = (x < 0) ? 0 : x;
      end else begin
        a  = (x < 0) ? -x : x;
        mm = (a < 16) ? 3 * a : ((a < 32) ? a + 32 : 64);
        y  = (x < 0) ? -mm : mm;
      end
      if (!m[i]) y = 0;
      r[i*8 +: 8] = y[7:0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic t, input logic [7:0] m, input logic [63:0] d,
                       input logic [63:0] e, input bit push);
    sb_t s;
    @(posedge clk);
    #1;
    activation_type   = t;
    validity_mask     = m;
    inp_data          = d;
    in_data_available = 1'b1;
    if (push) begin
      s.data = e;
      s.cyc  = cyc + 2;
      sb.push_back(s);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_data_available = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d beats outstanding, want 0", sb.size());
    end
  endtask

  // Scoreboard monitor with a running model of the tile-done flag
  always @(negedge clk) begin : mon
    sb_t e;
    if (mon_en) begin
      tests++;
      if (done_activation !== exp_done) begin
        fails++;
        $display("FAIL done_timing: got %b want %b at cycle %0d", done_activation, exp_done, cyc);
      end
      if (out_data_available === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h at cycle %0d, want no beat", out_data, cyc);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || cyc != e.cyc) begin
            fails++;
            $display("FAIL beat: got %h at cycle %0d want %h at cycle %0d", out_data, cyc, e.data, e.cyc);
          end
        end
        seen++;
        if (seen >= 8) exp_done = 1'b1;
      end
    end
  end

  initial begin
    vecs[0] = '{1'b0, 8'hFF, pk(-5, 3, 0, 127, -128, 1, -1, 64), pk(0, 3, 0, 127, 0, 1, 0, 64)};
    vecs[1] = '{1'b1, 8'hFF, pk(10, -20, 40, -128, 0, 15, 16, 31), pk(30, -52, 64, -64, 0, 45, 48, 63)};
    vecs[2] = '{1'b0, 8'h0F, pk(50, 50, 50, 50, 50, 50, 50, 50), pk(50, 50, 50, 50, 0, 0, 0, 0)};
    vecs[3] = '{1'b1, 8'hA5, pk(-1, -15, -16, -31, -32, 127, 1, -5), pk(-3, 0, -48, 0, 0, 64, 0, -15)};
    vecs[4] = '{1'b0, 8'hFF, pk(127, -127, 2, -2, 100, -100, 8, 0), pk(127, 0, 2, 0, 100, 0, 8, 0)};
    vecs[5] = '{1'b1, 8'hFF, pk(32, 33, -33, 14, -14, 47, -47, 17), pk(64, 64, -64, 42, -42, 64, -64, 49)};
    for (int i = 0; i < 8; i++) begin
      rd[i] = {$urandom, $urandom};
      rt[i] = 1'($urandom_range(0, 1));
      rm[i] = (i % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
    end
    rd[2][15:8] = 8'h80;

    reset = 1'b1;
    enable_activation = 1'b1;
    activation_type = 1'b0;
    in_data_available = 1'b0;
    inp_data = 64'd0;
    validity_mask = 8'hFF;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_avail", {63'd0, out_data_available}, 64'd0);
    chk("reset_done", {63'd0, done_activation}, 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].t, vecs[i].m, vecs[i].d, vecs[i].e, 1'b1);
      idle(1);
    end
    drain();
    idle(2);

    // Bypass: everything combinational, done forced high
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    enable_activation = 1'b0;
    in_data_available = 1'b1;
    inp_data = 64'h80FF_80FF_80FF_80FF;
    #1;
    chk("bypass_data", out_data, 64'h80FF_80FF_80FF_80FF);
    chk("bypass_avail_hi", {63'd0, out_data_available}, 64'd1);
    chk("bypass_done", {63'd0, done_activation}, 64'd1);
    #2;
    in_data_available = 1'b0;
    #1;
    chk("bypass_avail_lo", {63'd0, out_data_available}, 64'd0);
    #1;
    inp_data = 64'h0123_4567_89AB_CDEF;
    in_data_available = 1'b1;
    #1;
    chk("bypass_data2", out_data, 64'h0123_4567_89AB_CDEF);
    chk("bypass_avail_hi2", {63'd0, out_data_available}, 64'd1);
    @(posedge clk);
    #1;
    chk("bypass_done_edge", {63'd0, done_activation}, 64'd1);
    in_data_available = 1'b0;
    @(posedge clk);
    #1;
    enable_activation = 1'b1;
    #1;
    chk("reenable_data_cleared", out_data, 64'd0);
    chk("reenable_avail", {63'd0, out_data_available}, 64'd0);
    chk("reenable_done_cleared", {63'd0, done_activation}, 64'd0);
    seen = 0;
    exp_done = 1'b0;
    mon_en = 1'b1;

    // Eight back-to-back beats complete a tile
    for (int i = 0; i < 8; i++) drive(rt[i], rm[i], rd[i], model(rt[i], rm[i], rd[i]), 1'b1);
    idle(1);
    drain();
    idle(3);

    // Same eight beats with three-cycle gaps after a clear
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    enable_activation = 1'b0;
    @(posedge clk);
    #1;
    enable_activation = 1'b1;
    seen = 0;
    exp_done = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(rt[i], rm[i], rd[i], model(rt[i], rm[i], rd[i]), 1'b1);
      idle(3);
    end
    drain();
    idle(3);

    // Asynchronous reset with two beats in flight
    mon_en = 1'b0;
    drive(1'b0, 8'hFF, pk(1, 2, 3, 4, 5, 6, 7, 8), 64'd0, 1'b0);
    drive(1'b1, 8'hFF, pk(9, 9, 9, 9, 9, 9, 9, 9), 64'd0, 1'b0);
    @(posedge clk);
    #1;
    in_data_available = 1'b0;
    #1;
    chk("inflight_avail", {63'd0, out_data_available}, 64'd1);
    chk("inflight_data", out_data, pk(1, 2, 3, 4, 5, 6, 7, 8));
    chk("pre_reset_done", {63'd0, done_activation}, 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_data", out_data, 64'd0);
    chk("async_reset_avail", {63'd0, out_data_available}, 64'd0);
    chk("async_reset_done", {63'd0, done_activation}, 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    seen = 0;
    exp_done = 1'b0;
    mon_en = 1'b1;
    idle(6);
    for (int i = 0; i < 8; i++) drive(~rt[i], 8'hFF, rd[7-i], model(~rt[i], 8'hFF, rd[7-i]), 1'b1);
    idle(1);
    drain();
    idle(2);
    chk("restart_done", {63'd0, done_activation}, 64'd1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
